rca_ft: RTL and testbench
=========================

# rca_ft

4-bit ripple-carry adder built from four full-adder slices plus one spare slice, with fault injection, per-slice fault detection and automatic spare substitution. It serves as the fault-tolerant arithmetic test vehicle:
- A built-in self-test applies 3-bit truth-table patterns to every slice.
- A concurrent checker compares every slice against a golden full-adder table during normal additions.
- Sticky per-slice fault flags steer the spare slice into the lowest faulty position.

## Interface
Parameters: none; width fixed at 4.
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- a  in  4  addend A
- b  in  4  addend B; carry-in of slice 0 is constant 0
- init  in  1  synchronous self-test / initialize phase, active high
- test  in  1  enables fault checking (self-test and concurrent)
- f1  in  1  fault injection: inverts sum output of slice 1
- f2  in  1  fault injection: inverts carry output of slice 2
- lut_i  in  3  self-test pattern {a_bit, b_bit, cin}, MSB = a_bit
- s  out  4  registered sum
- sf  out  4  sticky sum-fault flags, bit i = slice i
- cf  out  4  sticky carry-fault flags, bit i = slice i
- cout  out  1  registered carry-out

## Operation
Slices:
- Each slice i computes sum = x^y^c and carry = xy|xc|yc.
- Injection is applied after each slice's output.
- Injection never affects the spare slice or the golden reference.

Self-test (init=1):
- All four slices are driven with x,y,c = lut_i[2], lut_i[1], lut_i[0].
- If test=1, each slice output is compared to the golden table entry for lut_i.
- A sum mismatch sets sf[i]; a carry mismatch sets cf[i].
- s and cout are loaded with 0 each edge.

Normal mode (init=0):
- Slices are chained as a ripple-carry adder: c0=0, slice i output carry feeds slice i+1, slice 3 carry is cout.
- If test=1, each slice's actual outputs are compared to the golden table evaluated on that slice's actual inputs.
- Mismatches set the sf/cf bits as in self-test.

Repair:
- k is the lowest index with sf[k]|cf[k]=1.
- The spare slice receives slice k's inputs; its sum and carry replace slice k's in the chain and in s.
- Only one slice is repaired. Additional flagged slices still propagate their faulty outputs.
- The concurrent checker continues to evaluate the replaced slice's own outputs; those flags are already set.

Flags:
- Sticky: cleared only by rst_n.
- init and test never clear flags.
- test=0 freezes the flags.

Registering: s and cout register the repaired chain result each edge while init=0. Arithmetic is modulo 16, with the overflow on cout.

## Timing
- Reset (rst_n=0, async): s=0, cout=0, sf=0, cf=0; held until rst_n rises.
- Result latency:
  - Inputs sampled at edge N; s/cout valid after edge N.
  - No handshake; a new operand pair is accepted every cycle.
- Flag latency:
  - A mismatch present before edge N sets its flag at edge N.
  - s captured at that same edge N is still uncorrected.
  - Repair affects results captured from edge N+1.
- init toggling mid-stream:
  - The first edge with init=1 clears s/cout.
  - The first edge with init=0 captures a normal result.
- f1/f2 changing mid-operation takes effect combinationally, on the next captured result and next check.
- rst_n asserted mid-operation clears everything immediately, including the repair selection.

## Test plan
- Reset, init=0, test=1, f=0; a=0101, b=0011 -> after one edge s=1000, cout=0, sf=cf=0000.
- a=1111, b=0001, no faults -> s=0000, cout=1; a=1110, b=1101 -> s=1011, cout=1.
- test=0, f1=1; a=0101, b=0011 -> s=1010, cout=0; flags remain 0000.
- test=1, f2=1; a=1111, b=0001:
  - first edge: s=1000, cout=0, cf=0100;
  - next edge: s=0000, cout=1 (spare repairs slice 2).
- init=1, test=1, f1=1, lut_i=000 -> after one edge sf=0010, cf=0000, s=0, cout=0. Then init=0, a=0101, b=0011 -> s=1000 (slice 1 repaired).
- f1=1 and f2=1, test=1, after flags set (sf=0010, cf=0100):
  - a=1111, b=0001 -> s=1000, cout=0; only slice 1 is repaired.
  - Assert rst_n=0 -> all outputs 0 immediately.

Source files
------------

// File: rtl/rca_ft_if.sv
// Operand/result bundle for the fault-tolerant ripple-carry adder.
// Latency: none (signal grouping only).
// Backpressure: none; the adder accepts a new operand pair every cycle.
// Ports: a/b operands, init/test/f1/f2/lut_i control, s/cout/sf/cf results.
interface rca_ft_if;
    logic [3:0] a;
    logic [3:0] b;
    logic       init;
    logic       test;
    logic       f1;
    logic       f2;
    logic [2:0] lut_i;
    logic [3:0] s;
    logic [3:0] sf;
    logic [3:0] cf;
    logic       cout;

    // Stimulus side drives operands and control and observes the results.
    modport master (
        output a, b, init, test, f1, f2, lut_i,
        input  s, sf, cf, cout
    );

    // Adder side.
    modport slave (
        input  a, b, init, test, f1, f2, lut_i,
        output s, sf, cf, cout
    );
endinterface

// File: rtl/rca_ft.sv
// 4-bit ripple-carry adder with fault injection, per-slice checking and spare-slice repair.
// Latency: 1 cycle from operands to s/cout; a mismatch sets its flag at the same edge.
// Backpressure: none; a new operand pair is taken every cycle.
// Ports: clk, rst_n (async active-low); bus.slave carries a, b, init, test, f1, f2,
//        lut_i in and s, cout, sf, cf out.
module rca_ft (
    input  logic     clk,
    input  logic     rst_n,
    rca_ft_if.slave  bus
);

    logic [3:0] flags;
    logic [3:0] rep_sel;
    logic [3:0] sum_err;
    logic [3:0] car_err;
    logic [3:0] res_s;
    logic       res_c;
    logic       carry;
    logic       x, y, c;
    logic       gold_s, gold_c;
    logic       act_s, act_c;

    // Spare goes to the lowest flagged slice only (isolate lowest set bit).
    assign flags   = bus.sf | bus.cf;
    assign rep_sel = flags & (~flags + 4'd1);

    always_comb begin
        sum_err = '0;
        car_err = '0;
        res_s   = '0;
        carry   = 1'b0;
        x       = 1'b0;
        y       = 1'b0;
        c       = 1'b0;
        gold_s  = 1'b0;
        gold_c  = 1'b0;
        act_s   = 1'b0;
        act_c   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (bus.init) begin
                x = bus.lut_i[2];
                y = bus.lut_i[1];
                c = bus.lut_i[0];
            end else begin
                x = bus.a[i];
                y = bus.b[i];
                c = carry;          // repaired carry from the slice below
            end
            gold_s = x ^ y ^ c;
            gold_c = (x & y) | (x & c) | (y & c);
            // Injection sits after the slice outputs; golden and spare are untouched.
            act_s  = gold_s ^ ((i == 1) && bus.f1);
            act_c  = gold_c ^ ((i == 2) && bus.f2);
            sum_err[i] = act_s ^ gold_s;
            car_err[i] = act_c ^ gold_c;
            // The spare sees the same inputs as the slice it replaces and is
            // fault-free, so its outputs equal the golden evaluation here.
            if (rep_sel[i]) begin
                res_s[i] = gold_s;
                carry    = gold_c;
            end else begin
                res_s[i] = act_s;
                carry    = act_c;
            end
        end
        res_c = carry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.s    <= '0;
            bus.cout <= 1'b0;
        end else if (bus.init) begin
            bus.s    <= '0;
            bus.cout <= 1'b0;
        end else begin
            bus.s    <= res_s;
            bus.cout <= res_c;
        end
    end

    // Flags are sticky; only reset clears them, test=0 freezes them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.sf <= '0;
            bus.cf <= '0;
        end else if (bus.test) begin
            bus.sf <= bus.sf | sum_err;
            bus.cf <= bus.cf | car_err;
        end
    end

endmodule

// File: tb/tb_rca_ft.sv
// Scoreboard bench for rca_ft: driver pushes hand-computed results, monitor compares.
// Latency: expectations are pushed 1 ns after the capturing edge, checked on the falling edge.
// Backpressure: none; one vector per cycle.
module tb_rca_ft;
    logic clk = 1'b0;
    logic rst_n;

    rca_ft_if bus ();

    rca_ft dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Packed expectation: {s, cout, sf, cf}
    typedef struct packed {
        logic [3:0] s;
        logic       cout;
        logic [3:0] sf;
        logic [3:0] cf;
    } exp_t;

    exp_t   exp_q[$];
    string  name_q[$];
    int     checks = 0;
    int     errors = 0;

    // Monitor: outputs are registered, so the falling edge is a stable sample point.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            exp_t  got;
            string n;
            e   = exp_q.pop_front();
            n   = name_q.pop_front();
            got = '{s: bus.s, cout: bus.cout, sf: bus.sf, cf: bus.cf};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL %s: got s=%b cout=%b sf=%b cf=%b, want s=%b cout=%b sf=%b cf=%b",
                         n, got.s, got.cout, got.sf, got.cf, e.s, e.cout, e.sf, e.cf);
            end
        end
    end

    task automatic expect_out(input string n, input logic [3:0] s, input logic co,
                              input logic [3:0] sf, input logic [3:0] cf);
        exp_t e;
        e = '{s: s, cout: co, sf: sf, cf: cf};
        exp_q.push_back(e);
        name_q.push_back(n);
    endtask

    // One clocked vector: drive, capture on the rising edge, then queue the expectation.
    task automatic step(input string n, input logic ini, input logic tst,
                        input logic i1, input logic i2, input logic [2:0] lut,
                        input logic [3:0] av, input logic [3:0] bv,
                        input logic [3:0] s, input logic co,
                        input logic [3:0] sf, input logic [3:0] cf);
        @(negedge clk);
        bus.init  = ini;
        bus.test  = tst;
        bus.f1    = i1;
        bus.f2    = i2;
        bus.lut_i = lut;
        bus.a     = av;
        bus.b     = bv;
        @(posedge clk);
        #1;
        expect_out(n, s, co, sf, cf);
    endtask

    // Asynchronous reset between edges; outputs must clear without a clock edge.
    task automatic pulse_reset(input string n);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 expect_out(n, 4'b0000, 1'b0, 4'b0000, 4'b0000);
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        bus.a     = 4'b0000;
        bus.b     = 4'b0000;
        bus.init  = 1'b0;
        bus.test  = 1'b1;
        bus.f1    = 1'b0;
        bus.f2    = 1'b0;
        bus.lut_i = 3'b000;
        #1 expect_out("reset", 4'b0000, 1'b0, 4'b0000, 4'b0000);
        #21 rst_n = 1'b1;

        //     name           init test f1 f2 lut     a        b        s        cout  sf       cf
        step("add_5_3",       0,   1,   0, 0, 3'b000, 4'b0101, 4'b0011, 4'b1000, 1'b0, 4'b0000, 4'b0000);
        step("add_15_1",      0,   1,   0, 0, 3'b000, 4'b1111, 4'b0001, 4'b0000, 1'b1, 4'b0000, 4'b0000);
        step("add_14_13",     0,   1,   0, 0, 3'b000, 4'b1110, 4'b1101, 4'b1011, 1'b1, 4'b0000, 4'b0000);
        step("add_0_0",       0,   1,   0, 0, 3'b000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000);
        step("add_8_8",       0,   1,   0, 0, 3'b000, 4'b1000, 4'b1000, 4'b0000, 1'b1, 4'b0000, 4'b0000);
        step("f1_notest_a",   0,   0,   1, 0, 3'b000, 4'b0101, 4'b0011, 4'b1010, 1'b0, 4'b0000, 4'b0000);
        step("f1_notest_b",   0,   0,   1, 0, 3'b000, 4'b0111, 4'b0001, 4'b1010, 1'b0, 4'b0000, 4'b0000);
        step("f2_detect",     0,   1,   0, 1, 3'b000, 4'b1111, 4'b0001, 4'b1000, 1'b0, 4'b0000, 4'b0100);
        step("f2_repaired",   0,   1,   0, 1, 3'b000, 4'b1111, 4'b0001, 4'b0000, 1'b1, 4'b0000, 4'b0100);
        pulse_reset("reset_clear_flags");
        step("bist_f1",       1,   1,   1, 0, 3'b000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0010, 4'b0000);
        step("f1_repaired",   0,   1,   1, 0, 3'b000, 4'b0101, 4'b0011, 4'b1000, 1'b0, 4'b0010, 4'b0000);
        step("dual_detect",   0,   1,   1, 1, 3'b000, 4'b1111, 4'b0001, 4'b1000, 1'b0, 4'b0010, 4'b0100);
        step("dual_one_fix",  0,   1,   1, 1, 3'b000, 4'b1111, 4'b0001, 4'b1000, 1'b0, 4'b0010, 4'b0100);
        step("bist_clears_s", 1,   1,   1, 1, 3'b111, 4'b1111, 4'b0001, 4'b0000, 1'b0, 4'b0010, 4'b0100);
        pulse_reset("reset_mid_op");

        // Drain the scoreboard with a bounded wait.
        for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(posedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
